// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the memory BIST controller.
// Bit e of each table describes march element e.
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int unsigned N_ELEM    = 6;
  localparam logic [2:0]  LAST_ELEM = 3'(N_ELEM - 1);

  // E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 up r0
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  localparam logic [7:0] OP0_READ     = 8'b0011_1110;
  localparam logic [7:0] OP0_DATA     = 8'b0001_0100;
  localparam logic [7:0] OP1_DATA     = 8'b0000_1010;

  // Write value, or expected read value, of op 'op' in element 'e'.
  function automatic logic op_data(input logic [2:0] e, input logic op);
    return op ? OP1_DATA[e] : OP0_DATA[e];
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for march elements: load sets direction and the
// first address of the element, last flags the final address in that direction.
module mbist_addr_gen #(
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [AWIDTH-1:0] addr,
  output logic              last
);

  logic down;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for a bit-wide RAM: issues one op per cycle,
// compares registered read data one cycle later and records the result.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [AWIDTH-1:0] first_fail_addr,
  output logic [2:0]        first_fail_elem,
  output logic [AWIDTH-1:0] mem_wr_addr,
  output logic [AWIDTH-1:0] mem_rd_addr,
  output logic              mem_din,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_dout
);

  state_t              state;
  logic [2:0]          elem;
  logic                op;
  logic                last_issued;

  logic [AWIDTH-1:0]   ag_addr;
  logic                ag_last, ag_load, ag_load_down, ag_step;
  logic                cur_read, cur_data, last_op, elem_end, test_end, issue;

  // Read side-band travels with mem_re so it lines up with mem_dout.
  logic                iss_exp;
  logic [2:0]          iss_elem;
  logic                cmp_vld, cmp_exp;
  logic [AWIDTH-1:0]   cmp_addr;
  logic [2:0]          cmp_elem;
  logic                mism;

  mbist_addr_gen #(.AWIDTH(AWIDTH)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    cur_read     = !op && OP0_READ[elem];
    cur_data     = op_data(elem, op);
    last_op      = op || !ELEM_TWO_OPS[elem];
    elem_end     = last_op && ag_last;
    test_end     = elem_end && (elem == LAST_ELEM);
    issue        = (state == ST_IDLE && start) || (state == ST_RUN && !last_issued);
    ag_step      = issue && last_op && !ag_last;
    // Outside of issuing, park the counter at address 0 counting up.
    ag_load      = issue ? (elem_end && !test_end) : 1'b1;
    ag_load_down = issue && ELEM_DOWN[elem + 3'd1];
    mism         = cmp_vld && (mem_dout != cmp_exp);
  end

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      elem            <= '0;
      op              <= 1'b0;
      last_issued     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err             <= 1'b0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_elem <= '0;
      mem_wr_addr     <= '0;
      mem_rd_addr     <= '0;
      mem_din         <= 1'b0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      iss_exp         <= 1'b0;
      iss_elem        <= '0;
      cmp_vld         <= 1'b0;
      cmp_exp         <= 1'b0;
      cmp_addr        <= '0;
      cmp_elem        <= '0;
    end else begin
      done     <= 1'b0;
      err      <= mism;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      cmp_vld  <= mem_re;
      cmp_exp  <= iss_exp;
      cmp_addr <= mem_rd_addr;
      cmp_elem <= iss_elem;

      if (mism) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (fail_cnt == '0) begin
          first_fail_addr <= cmp_addr;
          first_fail_elem <= cmp_elem;
        end
      end

      if (issue) begin
        if (cur_read) begin
          mem_re      <= 1'b1;
          mem_rd_addr <= ag_addr;
          iss_exp     <= cur_data;
          iss_elem    <= elem;
        end else begin
          mem_we      <= 1'b1;
          mem_wr_addr <= ag_addr;
          mem_din     <= cur_data;
        end
        if (!last_op) begin
          op <= 1'b1;
        end else begin
          op <= 1'b0;
          if (test_end)      last_issued <= 1'b1;
          else if (elem_end) elem        <= elem + 3'd1;
        end
      end

      case (state)
        ST_IDLE: if (start) begin
          state           <= ST_RUN;
          busy            <= 1'b1;
          pass            <= 1'b0;
          fail_cnt        <= '0;
          first_fail_addr <= '0;
          first_fail_elem <= '0;
        end
        ST_RUN: if (last_issued) state <= ST_FLUSH;
        ST_FLUSH: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          // The final compare lands on this same edge.
          pass  <= (fail_cnt == '0) && !mism;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          elem        <= '0;
          op          <= 1'b0;
          last_issued <= 1'b0;
        end
      endcase
    end
  end

endmodule
